// File: rtl/des_round_ctrl.sv
// des_round_ctrl: sequencing controller for the DES datapath.
// Walks one request through IP -> ROUNDS Feistel rounds -> final permutation,
// driving round index and key-shift schedule, all outputs registered.
// Optional feature macro: DES_FP_TIMEOUT_EN (bounded wait on fp_ready, err on expiry).
module des_round_ctrl #(
    parameter int unsigned ROUNDS     = 16,
    parameter int unsigned FP_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       decrypt,
    input  logic       fp_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       load_block,
    output logic       ip_start,
    output logic       round_en,
    output logic [3:0] round_idx,
    output logic [1:0] key_shift,
    output logic       key_dir,
    output logic       last_round,
    output logic       fp_start
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_IP    = 3'd1;
    localparam logic [2:0] S_ROUND = 3'd2;
    localparam logic [2:0] S_FP    = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [3:0] LAST_IDX = 4'(ROUNDS - 1);

    // Reject out-of-range configurations at elaboration time
    if (ROUNDS < 1 || ROUNDS > 16 || FP_TIMEOUT < 1) begin : g_bad_cfg
        $error("des_round_ctrl: ROUNDS must be 1..16 and FP_TIMEOUT >= 1");
    end

    logic [2:0] state_q, state_d;
    logic [3:0] round_q, round_d;
    logic       mode_q, mode_d;

    logic       busy_q, done_q, load_q, ip_start_q, round_en_q;
    logic [1:0] key_shift_q, key_shift_d;
    logic       key_dir_q, last_round_q, fp_start_q;

`ifdef DES_FP_TIMEOUT_EN
    localparam int unsigned FPW = (FP_TIMEOUT > 1) ? $clog2(FP_TIMEOUT) : 1;
    localparam logic [FPW-1:0] FP_LAST = FPW'(FP_TIMEOUT - 1);
    logic [FPW-1:0] fp_cnt_q, fp_cnt_d;
    logic           timeout_d, err_q;
`endif

    // Key rotate amount: decrypt skips the rotate before round 0
    function automatic logic [1:0] shift_sched(input logic [3:0] idx, input logic dec);
        if (dec && idx == 4'd0)
            return 2'd0;
        else if (idx == 4'd0 || idx == 4'd1 || idx == 4'd8 || idx == 4'd15)
            return 2'd1;
        else
            return 2'd2;
    endfunction

    // Next-state logic for the sequencer, round counter and mode register
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        mode_d  = mode_q;
`ifdef DES_FP_TIMEOUT_EN
        fp_cnt_d  = fp_cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_IP;
                    mode_d  = decrypt;
                end
            end
            S_IP: begin
                state_d = S_ROUND;
                round_d = '0;
            end
            S_ROUND: begin
                if (round_q == LAST_IDX) begin
                    state_d = S_FP;
                    round_d = '0;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            S_FP: begin
                if (fp_ready) begin
                    state_d = S_DONE;
`ifdef DES_FP_TIMEOUT_EN
                    fp_cnt_d = '0;
                end else if (fp_cnt_q == FP_LAST) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                    fp_cnt_d  = '0;
                end else begin
                    fp_cnt_d = fp_cnt_q + 1'b1;
`endif
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        key_shift_d = (state_d == S_ROUND) ? shift_sched(round_d, mode_d) : 2'd0;
    end

    // State and registered outputs, derived from the next state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            round_q      <= '0;
            mode_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            load_q       <= 1'b0;
            ip_start_q   <= 1'b0;
            round_en_q   <= 1'b0;
            key_shift_q  <= '0;
            key_dir_q    <= 1'b0;
            last_round_q <= 1'b0;
            fp_start_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            round_q      <= round_d;
            mode_q       <= mode_d;
            busy_q       <= (state_d != S_IDLE);
            done_q       <= (state_d == S_DONE);
            load_q       <= (state_d == S_IP);
            ip_start_q   <= (state_d == S_IP);
            round_en_q   <= (state_d == S_ROUND);
            key_shift_q  <= key_shift_d;
            key_dir_q    <= (state_d == S_ROUND) && mode_d;
            last_round_q <= (state_d == S_ROUND) && (round_d == LAST_IDX);
            fp_start_q   <= (state_d == S_FP);
        end
    end

`ifdef DES_FP_TIMEOUT_EN
    // FP dwell counter and timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fp_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            fp_cnt_q <= fp_cnt_d;
            err_q    <= timeout_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy       = busy_q;
    assign done       = done_q;
    assign load_block = load_q;
    assign ip_start   = ip_start_q;
    assign round_en   = round_en_q;
    assign round_idx  = round_q;
    assign key_shift  = key_shift_q;
    assign key_dir    = key_dir_q;
    assign last_round = last_round_q;
    assign fp_start   = fp_start_q;

endmodule

// File: tb/tb_des_round_ctrl.sv
// Directed bench for des_round_ctrl (ROUNDS=16, FP_TIMEOUT=8).
// Honours DES_FP_TIMEOUT_EN for the FP-timeout expectations.
module tb_des_round_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       decrypt = 1'b0;
    logic       fp_ready = 1'b0;
    logic       busy, done, err, load_block, ip_start, round_en;
    logic [3:0] round_idx;
    logic [1:0] key_shift;
    logic       key_dir, last_round, fp_start;
    logic [14:0] obs;

    int total = 0;
    int bad   = 0;

    des_round_ctrl #(.ROUNDS(16), .FP_TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .decrypt(decrypt), .fp_ready(fp_ready),
        .busy(busy), .done(done), .err(err), .load_block(load_block), .ip_start(ip_start),
        .round_en(round_en), .round_idx(round_idx), .key_shift(key_shift), .key_dir(key_dir),
        .last_round(last_round), .fp_start(fp_start)
    );

    always #5 clk = ~clk;

    assign obs = {busy, done, err, load_block, ip_start, round_en, round_idx,
                  key_shift, key_dir, last_round, fp_start};

    // Key-shift schedules, two bits per round, round 0 in the LSBs
    localparam logic [31:0] ENC_KS = 32'h6AA9_AAA5;
    localparam logic [31:0] DEC_KS = 32'h6AA9_AAA4;

    typedef struct {
        string       name;
        logic        dec;
        logic [31:0] ks;
        int          fp_delay;  // FP cycles before fp_ready is pulsed
        int          stray_c;   // cycle offset of an fp_ready pulse that must be ignored (-1 none)
        int          done_at;   // expected done cycle offset from the start cycle
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input int c, input logic [14:0] got, input logic [14:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, c, got, exp);
        end
    endtask

    // One full request from an idle negedge; checks every output every cycle
    task automatic run_vec(input vec_t v);
        logic [14:0] exp;
        logic        b, d, lb, re, kd, lr, fs;
        logic [3:0]  ridx;
        logic [1:0]  ks;
        @(negedge clk);
        start = 1'b1;
        decrypt = v.dec;
        chk({v.name, "_idle"}, 0, obs, '0);
        for (int c = 1; c <= v.done_at + 1; c++) begin
            @(negedge clk);
            start = 1'b0;
            decrypt = ~v.dec;
            fp_ready = (c == 18 + v.fp_delay) || (c == v.stray_c);
            b    = (c >= 1) && (c <= v.done_at);
            d    = (c == v.done_at);
            lb   = (c == 1);
            re   = (c >= 2) && (c <= 17);
            ridx = re ? 4'(c - 2) : 4'd0;
            ks   = re ? v.ks[2*(c-2) +: 2] : 2'd0;
            kd   = re && v.dec;
            lr   = (c == 17);
            fs   = (c >= 18) && (c < v.done_at);
            exp  = {b, d, 1'b0, lb, lb, re, ridx, ks, kd, lr, fs};
            chk(v.name, c, obs, exp);
        end
        fp_ready = 1'b0;
        decrypt = 1'b0;
    endtask

    initial begin
        int dones;
        vecs[0] = '{name: "enc",       dec: 1'b0, ks: ENC_KS, fp_delay: 2, stray_c: 5,  done_at: 21};
        vecs[1] = '{name: "dec",       dec: 1'b1, ks: DEC_KS, fp_delay: 2, stray_c: -1, done_at: 21};
        vecs[2] = '{name: "enc_fast",  dec: 1'b0, ks: ENC_KS, fp_delay: 0, stray_c: 19, done_at: 19};
        vecs[3] = '{name: "dec_slow",  dec: 1'b1, ks: DEC_KS, fp_delay: 5, stray_c: 1,  done_at: 24};

        // Reset values
        repeat (3) @(negedge clk);
        chk("reset_hold", 0, obs, '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_rel", 0, obs, '0);

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // start held high: accepted at 0 and 22 only
        @(negedge clk);
        start = 1'b1;
        decrypt = 1'b0;
        for (int c = 0; c <= 44; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 44) start = 1'b0;
            fp_ready = (c == 20) || (c == 42);
            chk("hold_start", c, {15'(ip_start), 15'(done), 15'(busy)} == 45'd0 ? 15'd0 : {12'd0, ip_start, done, busy},
                {12'd0, (c == 1) || (c == 23), (c == 21) || (c == 43),
                 ((c >= 1) && (c <= 21)) || ((c >= 23) && (c <= 43))});
        end
        fp_ready = 1'b0;

        // Abort in round 7
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("abort_idx", 9, {11'd0, round_idx}, 15'd7);
        #1 rst_n = 1'b0;
        #1 chk("abort_async", 9, obs, '0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        chk("abort_nodone", 0, 15'(dones), 15'd0);
        run_vec(vecs[0]);

        // fp_ready never comes
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            start = 1'b0;
`ifdef DES_FP_TIMEOUT_EN
            chk("fp_timeout", c, {12'd0, done, err, fp_start},
                {12'd0, c == 26, c == 26, (c >= 18) && (c < 26)});
`else
            chk("fp_wait", c, {12'd0, done, err, fp_start}, {12'd0, 1'b0, 1'b0, c >= 18});
`endif
        end
`ifndef DES_FP_TIMEOUT_EN
        @(negedge clk);
        fp_ready = 1'b1;
        @(negedge clk);
        fp_ready = 1'b0;
        chk("fp_late_ready", 32, {13'd0, done, err}, 15'b10);
`endif
        run_vec(vecs[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
